sopc_timer: RTL and testbench

Memory-mapped programmable down-counter timer that acts as a responder on the CPU's data-memory bus, alongside `data_ram`. It decodes a 16-byte register window, serves single-cycle reads and byte-masked writes, and drives a level interrupt into one bit of the CPU's `int_i[5:0]` vector. It replaces the CP0-internal timer for software that needs a programmable period and auto-reload.

---
 rtl/sopc_timer_pkg.sv | 22 ++
 rtl/sopc_timer_if.sv | 12 +
 rtl/timer_prescaler.sv | 21 ++
 rtl/sopc_timer.sv | 56 +++++
 tb/tb_sopc_timer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_timer_pkg.sv
// sopc_timer_pkg: register map, bit positions and byte-merge helper shared by the timer files.
package sopc_timer_pkg;
    localparam int RegBus = 32;
    localparam logic [31:0] TimerBaseAddr = 32'h1000_0000;
    typedef enum logic [1:0] {
        TimerCtrlOff  = 2'd0,
        TimerLoadOff  = 2'd1,
        TimerCountOff = 2'd2,
        TimerStatOff  = 2'd3
    } timer_off_e;
    localparam int CtrlEn   = 0;
    localparam int CtrlAr   = 1;
    localparam int CtrlIe   = 2;
    localparam int StatPend = 0;
    function automatic logic [RegBus-1:0] byte_merge(input logic [RegBus-1:0] old_v,
                                                      input logic [RegBus-1:0] new_v,
                                                      input logic [3:0] sel);
        logic [RegBus-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = sel[i] ? new_v[8*i+:8] : old_v[8*i+:8];
        return r;
    endfunction
endpackage

// File: rtl/sopc_timer_if.sv
// sopc_timer_if: data-memory bus responder signals plus the timer interrupt line.
interface sopc_timer_if import sopc_timer_pkg::*; ();
    logic              ce;
    logic              we;
    logic [31:0]       addr;
    logic [3:0]        sel;
    logic [RegBus-1:0] data_i;
    logic [RegBus-1:0] data_o;
    logic              int_o;
    modport master (output ce, we, addr, sel, data_i, input data_o, int_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o, int_o);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every PRESCALE enabled cycles; phase restarts on enable.
module timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] Last = W'(PRESCALE - 1);
    logic [W-1:0] pc_q, pc_d;
    always_comb begin
        tick = en && pc_q == Last;
        pc_d = (!en || restart || tick) ? '0 : pc_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        pc_q <= rst ? '0 : pc_d;
    end
endmodule

// File: rtl/sopc_timer.sv
// sopc_timer: memory-mapped down-counter with auto-reload and level interrupt.
module sopc_timer import sopc_timer_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = TimerBaseAddr,
    parameter int          PRESCALE  = 4
) (
    input logic        clk,
    input logic        rst,
    sopc_timer_if.slave bus
);
    logic [2:0]        ctrl_q, ctrl_d;
    logic [RegBus-1:0] load_q, load_d, count_q, count_d;
    logic              pend_q, pend_d;
    logic              hit, wr, tick, run, expire, restart, clr;
    timer_off_e        off;
    logic              unused_addr;
    assign unused_addr = ^bus.addr[1:0];
    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk, .rst, .en(ctrl_q[CtrlEn]), .restart, .tick
    );
    always_comb begin
        hit     = bus.ce && bus.addr[31:4] == BASE_ADDR[31:4];
        off     = timer_off_e'(bus.addr[3:2]);
        wr      = hit && bus.we;
        run     = tick && ctrl_q[CtrlEn];
        expire  = run && count_q == 32'd1;
        restart = wr && off == TimerCtrlOff && bus.sel[0] && bus.data_i[CtrlEn] && !ctrl_q[CtrlEn];
        clr     = wr && off == TimerStatOff && bus.sel[0] && bus.data_i[StatPend];
        // bus writes override the one-shot EN auto-clear for the byte they touch
        ctrl_d  = (wr && off == TimerCtrlOff && bus.sel[0]) ? bus.data_i[2:0] :
                  (expire && !ctrl_q[CtrlAr]) ? {ctrl_q[2:1], 1'b0} : ctrl_q;
        load_d  = (wr && off == TimerLoadOff) ? byte_merge(load_q, bus.data_i, bus.sel) : load_q;
        count_d = (wr && off == TimerCountOff) ? byte_merge(count_q, bus.data_i, bus.sel) :
                  !run ? count_q :
                  count_q > 32'd1 ? count_q - 32'd1 :
                  expire ? (ctrl_q[CtrlAr] ? load_q : '0) : count_q;
        pend_d  = expire || (pend_q && !clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end
    assign bus.data_o = !(hit && !bus.we) ? '0 :
                        off == TimerCtrlOff  ? {29'b0, ctrl_q} :
                        off == TimerLoadOff  ? load_q :
                        off == TimerCountOff ? count_q : {31'b0, pend_q};
    assign bus.int_o  = pend_q && ctrl_q[CtrlIe];
endmodule

// File: tb/tb_sopc_timer.sv
// tb_sopc_timer: vector table, timing sequences and random traffic against a behavioural model.
module tb_sopc_timer;
    localparam int P = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] CTRL = BASE + 32'h0;
    localparam logic [31:0] LOAD = BASE + 32'h4;
    localparam logic [31:0] CNT  = BASE + 32'h8;
    localparam logic [31:0] STAT = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    sopc_timer_if bus();
    sopc_timer #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic        m_en, m_ar, m_ie, m_pend;
    logic [31:0] m_load, m_count;
    int          m_cyc;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] m_read(input logic ce, input logic we, input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (ce && !we && a[31:4] == BASE[31:4])
            case (a[3:2])
                2'd0:    r = {29'b0, m_ie, m_ar, m_en};
                2'd1:    r = m_load;
                2'd2:    r = m_count;
                default: r = {31'b0, m_pend};
            endcase
        return r;
    endfunction

    task automatic m_reset;
        m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0;
        m_load = 0; m_count = 0; m_cyc = 0;
    endtask

    // m_cyc = edges elapsed while enabled; a tick falls on every P-th of them
    task automatic m_step(input logic ce, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        logic tick, hitw, expired, ne, np;
        logic [31:0] nc;
        tick = m_en && (m_cyc % P == P - 1);
        m_cyc = m_en ? m_cyc + 1 : 0;
        hitw = ce && we && a[31:4] == BASE[31:4];
        expired = tick && m_count == 1;
        nc = m_count; ne = m_en; np = m_pend;
        if (tick && m_count > 1) nc = m_count - 1;
        if (expired) begin
            np = 1;
            nc = m_ar ? m_load : 32'h0;
            ne = m_ar;
        end
        if (hitw)
            case (a[3:2])
                2'd0: if (s[0]) {m_ie, m_ar, ne} = d[2:0];
                2'd1: m_load = merge(m_load, d, s);
                2'd2: nc = merge(m_count, d, s);
                default: if (s[0] && d[0] && !expired) np = 0;
            endcase
        m_en = ne; m_count = nc; m_pend = np;
    endtask

    task automatic cycle(input logic ce, input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic use_exp, input logic [31:0] exp, input string name);
        bus.ce = ce; bus.we = we; bus.addr = a; bus.sel = s; bus.data_i = d;
        @(negedge clk);
        chk("data_o_model", bus.data_o, m_read(ce, we, a));
        chk("int_o_model", {31'b0, bus.int_o}, {31'b0, m_ie & m_pend});
        if (use_exp) chk(name, bus.data_o, exp);
        @(posedge clk);
        m_step(ce, we, a, s, d);
        #1;
    endtask

    task automatic idle;
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, "idle");
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, 4'hF, d, 1'b0, 32'h0, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        cycle(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, exp, name);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.ce = 0; bus.we = 0; bus.addr = 0; bus.sel = 0; bus.data_i = 0;
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_int(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            idle();
            if (bus.int_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int r;
        logic [1:0] ro;
        logic [31:0] ra, rdat;
        logic [3:0] rs;

        vt[0]  = '{1'b1, 1'b0, CTRL, 4'h0, 32'h0, 32'h0, "rst_ctrl"};
        vt[1]  = '{1'b1, 1'b0, STAT, 4'h0, 32'h0, 32'h0, "rst_stat"};
        vt[2]  = '{1'b1, 1'b1, LOAD, 4'hF, 32'hAABBCCDD, 32'h0, "wr_load"};
        vt[3]  = '{1'b1, 1'b1, LOAD, 4'h5, 32'h11223344, 32'h0, "wr_load_mask"};
        vt[4]  = '{1'b1, 1'b0, LOAD, 4'h0, 32'h0, 32'hAA22CC44, "byte_mask"};
        vt[5]  = '{1'b1, 1'b0, BASE + 32'h7, 4'h0, 32'h0, 32'hAA22CC44, "addr_lsb_ignored"};
        vt[6]  = '{1'b1, 1'b1, CTRL, 4'hF, 32'hFFFFFFFE, 32'h0, "wr_ctrl"};
        vt[7]  = '{1'b1, 1'b0, CTRL, 4'h0, 32'h0, 32'h6, "ctrl_upper_zero"};
        vt[8]  = '{1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hFFFFFFFF, 32'h0, "wr_miss"};
        vt[9]  = '{1'b1, 1'b0, CTRL, 4'h0, 32'h0, 32'h6, "ctrl_after_miss"};
        vt[10] = '{1'b1, 1'b0, LOAD, 4'h0, 32'h0, 32'hAA22CC44, "load_after_miss"};
        vt[11] = '{1'b0, 1'b0, LOAD, 4'h0, 32'h0, 32'h0, "rd_ce_low"};
        vt[12] = '{1'b1, 1'b0, BASE + 32'h14, 4'h0, 32'h0, 32'h0, "rd_miss"};
        vt[13] = '{1'b1, 1'b1, CNT, 4'h3, 32'h12345678, 32'h0, "wr_count_mask"};
        vt[14] = '{1'b1, 1'b0, CNT, 4'h0, 32'h0, 32'h00005678, "count_mask"};
        vt[15] = '{1'b0, 1'b1, LOAD, 4'hF, 32'h0, 32'h0, "wr_ce_low"};
        vt[16] = '{1'b1, 1'b0, LOAD, 4'h0, 32'h0, 32'hAA22CC44, "load_after_ce_low"};
        vt[17] = '{1'b1, 1'b1, CTRL, 4'hF, 32'h0, 32'h0, "wr_ctrl_zero"};
        vt[18] = '{1'b1, 1'b0, CTRL, 4'h0, 32'h0, 32'h0, "ctrl_zero"};

        do_reset();
        foreach (vt[i])
            cycle(vt[i].ce, vt[i].we, vt[i].a, vt[i].s, vt[i].d, !vt[i].we, vt[i].exp, vt[i].name);

        // reset in the middle of a count
        do_reset();
        wr(CNT, 5);
        wr(CTRL, 32'h5);
        repeat (6) idle();
        do_reset();
        rd(CTRL, 0, "rst_mid_ctrl");
        rd(LOAD, 0, "rst_mid_load");
        rd(CNT, 0, "rst_mid_count");
        rd(STAT, 0, "rst_mid_stat");
        chk("rst_mid_int", {31'b0, bus.int_o}, 32'h0);

        // one-shot
        do_reset();
        wr(CNT, 3);
        wr(CTRL, 32'h5);
        wait_int(40, n);
        chk("oneshot_latency", n, 12);
        rd(CTRL, 32'h4, "oneshot_ctrl");
        rd(CNT, 0, "oneshot_count");
        rd(STAT, 1, "oneshot_pend");

        // auto-reload, clear, and clear colliding with expiry
        do_reset();
        wr(LOAD, 2);
        wr(CNT, 2);
        wr(CTRL, 32'h7);
        wait_int(40, n);
        chk("ar_first", n, 8);
        wr(STAT, 1);
        chk("ar_cleared", {31'b0, bus.int_o}, 32'h0);
        wait_int(40, n);
        chk("ar_period", n, 7);
        repeat (7) idle();
        wr(STAT, 1);
        chk("clear_on_expiry", {31'b0, bus.int_o}, 32'h1);
        wr(STAT, 1);
        chk("clear_after", {31'b0, bus.int_o}, 32'h0);

        // COUNT write on a tick edge
        do_reset();
        wr(CNT, 20);
        wr(CTRL, 32'h1);
        repeat (3) idle();
        wr(CNT, 9);
        rd(CNT, 9, "count_write_wins");

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 31);
            ro = 2'($urandom_range(0, 3));
            ra = BASE + {28'h0, ro, 2'($urandom_range(0, 3))};
            rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            rdat = (ro == 2'd1 || ro == 2'd2) ?
                   (($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 5)) : $urandom;
            if (r < 2) cycle(1'b1, 1'b1, ra, rs, rdat, 1'b0, 32'h0, "rand_wr");
            else if (r < 10) cycle(1'b1, 1'b0, ra, 4'($urandom), 32'h0, 1'b0, 32'h0, "rand_rd");
            else if (r == 10) cycle(1'b1, 1'b0, ra + 32'h20, 4'hF, 32'h0, 1'b1, 32'h0, "rand_rd_miss");
            else if (r == 11) cycle(1'b0, 1'($urandom), ra, rs, rdat, 1'b1, 32'h0, "rand_ce_low");
            else if (r == 12) cycle(1'b1, 1'b1, ra ^ 32'h100, rs, rdat, 1'b0, 32'h0, "rand_wr_miss");
            else idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
